// File: rtl/fp_pkg.sv
// Shared single-precision types and constants for the adder normalize/round path.
// No logic here, so no latency.
// No handshake here; flow control lives in the modules that import this package.
package fp_pkg;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = FRAC_W + 4;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Exponent carries one extra bit so an overflowing sum stays representable.
    typedef struct packed {
        logic              sign;
        logic [EXP_W:0]    exp;
        logic [MANT_W-1:0] mant;
    } raw_sum_t;

    typedef enum logic [1:0] {
        NR_IDLE,
        NR_NORM,
        NR_ROUND,
        NR_DONE
    } nr_state_e;

    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;
endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized or denormal mantissa, then exponent-field packing.
// Purely combinational: zero cycles.
// No handshake; the enclosing FSM decides when the outputs are captured.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int EW = 8,
    parameter int FW = 23
) (
    input  logic [FW+2:0] mant,
    input  logic [EW:0]   exp,
    output logic [FW-1:0] frac,
    output logic [EW-1:0] exp_field,
    output logic          inexact,
    output logic          overflow
);
    logic          round_up;
    logic          carry;
    logic          hidden;
    logic [FW+1:0] sum;
    logic [EW:0]   exp_post;

    assign round_up = mant[1] & (mant[0] | mant[2]);
    assign sum      = {1'b0, mant[FW+2:2]} + (FW+2)'(round_up);
    assign carry    = sum[FW+1];
    // A denormal that rounds into the hidden position becomes the smallest normal.
    assign hidden   = carry | sum[FW];
    assign exp_post = exp + (EW+1)'(carry);

    always_comb begin
        overflow = (exp_post >= (EW+1)'(EXP_MAX));
        inexact  = mant[1] | mant[0] | overflow;
        if (overflow) begin
            frac      = '0;
            exp_field = '1;
        end else begin
            frac      = carry ? sum[FW:1] : sum[FW-1:0];
            exp_field = hidden ? exp_post[EW-1:0] : '0;
        end
    end
endmodule

// File: rtl/fp_norm_round.sv
// Iterative normalize (one shift per cycle) + RNE rounding + pack for the fp adder.
// Latency 2 cycles normal/zero, 3 with carry, 2+k for k left shifts; no overlap.
// in_ready only in IDLE; result held in DONE until out_ready.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int EW = 8,
    parameter int FW = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [EW-1:0] in_exp,
    input  logic [FW+3:0] in_mant,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_result,
    output logic [2:0]    out_flags
);
    nr_state_e      state;
    nr_state_e      state_nxt;
    raw_sum_t       cur;
    logic           is_zero;
    logic           need_rshift;
    logic           need_lshift;
    logic [FW-1:0]  rnd_frac;
    logic [EW-1:0]  rnd_exp;
    logic           rnd_inx;
    logic           rnd_ovf;
    fp32_t          res_pk;
    logic [2:0]     flags_nxt;

    assign is_zero     = (cur.mant == '0);
    assign need_rshift = cur.mant[MANT_W-1];
    assign need_lshift = !is_zero && !need_rshift && !cur.mant[MANT_W-2]
                         && (cur.exp > (EXP_W+1)'(1));

    fp_round_rne #(.EW(EW), .FW(FW)) u_round (
        .mant      (cur.mant[MANT_W-2:0]),
        .exp       (cur.exp),
        .frac      (rnd_frac),
        .exp_field (rnd_exp),
        .inexact   (rnd_inx),
        .overflow  (rnd_ovf)
    );

    always_comb begin
        res_pk              = '{sign: cur.sign, exp: rnd_exp, frac: rnd_frac};
        flags_nxt           = '0;
        flags_nxt[FLAG_OVF] = rnd_ovf;
        flags_nxt[FLAG_UNF] = (rnd_exp == '0) && rnd_inx;
        flags_nxt[FLAG_INX] = rnd_inx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= NR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NR_IDLE:  if (in_valid) state_nxt = NR_NORM;
            NR_NORM:  if (!need_rshift && !need_lshift) state_nxt = NR_ROUND;
            NR_ROUND: state_nxt = NR_DONE;
            NR_DONE:  if (out_ready) state_nxt = NR_IDLE;
            default:  state_nxt = NR_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == NR_IDLE);
        out_valid = (state == NR_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= '0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            case (state)
                NR_IDLE: begin
                    if (in_valid) begin
                        cur.sign <= in_sign;
                        cur.exp  <= (in_exp == '0) ? (EXP_W+1)'(1) : {1'b0, in_exp};
                        cur.mant <= in_mant;
                    end
                end
                NR_NORM: begin
                    // Zero goes through ROUND with exp forced to 1 so it packs as a clean +-0.
                    if (is_zero) begin
                        cur.exp <= (EXP_W+1)'(1);
                    end else if (need_rshift) begin
                        cur.mant <= {1'b0, cur.mant[MANT_W-1:2], cur.mant[1] | cur.mant[0]};
                        cur.exp  <= cur.exp + (EXP_W+1)'(1);
                    end else if (need_lshift) begin
                        cur.mant <= {cur.mant[MANT_W-2:0], 1'b0};
                        cur.exp  <= cur.exp - (EXP_W+1)'(1);
                    end
                end
                NR_ROUND: begin
                    out_result <= res_pk;
                    out_flags  <= flags_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule
